demux2_reg: RTL and testbench

//  1-to-2 registered demultiplexer with valid/ready handshake; inverse direction of
//  the 2:1 select path. Steers one upstream word to output port 0 or 1 per sel_i.

---
 rtl/demux2_reg.sv | 90 +++++++++
 tb/tb_demux2_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux2_reg.sv
// demux2_reg: 1-to-2 registered demultiplexer with valid/ready handshake.
// A single-entry output register holds one word together with its destination
// port. The word is offered on that port until the sink accepts it. The block
// runs at full throughput and adds one cycle of latency.
// Optional feature macro: DEMUX2_CNT_EN adds per-port counters of completed
// transfers. Without it, cnt0_o and cnt1_o are constant zero.
module demux2_reg #(
    parameter int DataWidth = 32,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 sel_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out0_valid_o,
    input  logic                 out0_ready_i,
    output logic [DataWidth-1:0] out0_data_o,
    output logic                 out1_valid_o,
    input  logic                 out1_ready_i,
    output logic [DataWidth-1:0] out1_data_o,
    output logic [CntWidth-1:0]  cnt0_o,
    output logic [CntWidth-1:0]  cnt1_o
);

    logic                 r_full;
    logic                 r_dest;
    logic [DataWidth-1:0] r_data;

    logic w_pop;
    logic w_push;

    // Handshake decode. Only the ready of the port that holds the word matters.
    always_comb begin
        w_pop      = r_full & (r_dest ? out1_ready_i : out0_ready_i);
        in_ready_o = ~r_full | w_pop;
        w_push     = in_valid_i & in_ready_o;
    end

    // Output register: load on push, empty on a pop that has no push.
    // NOTE: sequential state uses non-blocking assignments only. Blocking
    // assignments here would let a later read in the same block see the new
    // value and create simulation/synthesis mismatches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full <= 1'b0;
            r_dest <= 1'b0;
            r_data <= '0;
        end else if (w_push) begin
            r_full <= 1'b1;
            r_dest <= sel_i;
            r_data <= in_data_i;
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end

    // Port outputs are driven only by registered state, so no combinational
    // path runs from the upstream inputs to any output.
    always_comb begin
        out0_valid_o = r_full & ~r_dest;
        out1_valid_o = r_full & r_dest;
        out0_data_o  = r_data;
        out1_data_o  = r_data;
    end

`ifdef DEMUX2_CNT_EN
    logic [CntWidth-1:0] r_cnt0;
    logic [CntWidth-1:0] r_cnt1;

    // Per-port completed-transfer counters. They wrap naturally at 2^CntWidth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_pop) begin
            if (r_dest) r_cnt1 <= r_cnt1 + 1'b1;
            else        r_cnt0 <= r_cnt0 + 1'b1;
        end
    end

    assign cnt0_o = r_cnt0;
    assign cnt1_o = r_cnt1;
`else
    assign cnt0_o = '0;
    assign cnt1_o = '0;
`endif

endmodule

// File: tb/tb_demux2_reg.sv
// tb_demux2_reg: scoreboard bench for demux2_reg (DataWidth=32, CntWidth=4).
// Every word is pushed to the queue when it is driven. Each handshake seen on
// an output port pops the queue and compares the port and the data.
module tb_demux2_reg;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic          sel;
        logic [DW-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          sel;
    logic [DW-1:0] in_data;
    logic          out0_valid, out1_valid;
    logic          out0_ready, out1_ready;
    logic [DW-1:0] out0_data, out1_data;
    logic [CW-1:0] cnt0, cnt1;

    item_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_pop = 0;
    int    cyc   = 0;

    demux2_reg #(.DataWidth(DW), .CntWidth(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .sel_i        (sel),
        .in_data_i    (in_data),
        .out0_valid_o (out0_valid),
        .out0_ready_i (out0_ready),
        .out0_data_o  (out0_data),
        .out1_valid_o (out1_valid),
        .out1_ready_i (out1_ready),
        .out1_data_o  (out1_data),
        .cnt0_o       (cnt0),
        .cnt1_o       (cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: sample between edges and score every port handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("exclusive_valid", {63'd0, out0_valid & out1_valid}, 64'd0);
            if ((out0_valid && out0_ready) || (out1_valid && out1_ready)) begin
                item_t exp_it;
                n_pop++;
                if (sb_q.size() == 0) begin
                    check("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    exp_it = sb_q.pop_front();
                    check("pop_port", {63'd0, out1_valid}, {63'd0, exp_it.sel});
                    check("pop_data", {32'd0, out1_valid ? out1_data : out0_data},
                          {32'd0, exp_it.data});
                end
            end
        end
    end

    // Offer one word and hold it until accepted. Called and returns at posedge+1.
    task automatic send(input logic s, input logic [DW-1:0] d);
        int waited = 0;
        item_t it;
        it.sel  = s;
        it.data = d;
        sb_q.push_back(it);
        in_valid = 1'b1;
        sel      = s;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                check("send_timeout", 64'd1, 64'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int p0;
        item_t it;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        sel        = 1'b0;
        in_data    = '0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        #1;
        check("rst_in_ready",   {63'd0, in_ready},   64'd1);
        check("rst_out0_valid", {63'd0, out0_valid}, 64'd0);
        check("rst_out1_valid", {63'd0, out1_valid}, 64'd0);
        check("rst_out0_data",  {32'd0, out0_data},  64'd0);
        check("rst_cnt0",       {60'd0, cnt0},       64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Single route to port 1: valid for exactly one cycle.
        send(1'b1, 32'hDEAD_BEEF);
        check("single_out1_valid", {63'd0, out1_valid}, 64'd1);
        check("single_out0_valid", {63'd0, out0_valid}, 64'd0);
        check("single_out1_data",  {32'd0, out1_data},  64'h0000_0000_DEAD_BEEF);
        step(1);
        check("single_one_cycle",  {63'd0, out1_valid}, 64'd0);

        // Backpressure on port 0. A second word is held upstream meanwhile, and
        // toggling the port 1 ready must not release anything.
        out0_ready = 1'b0;
        send(1'b0, 32'h11);
        in_valid = 1'b1;
        sel      = 1'b1;
        in_data  = 32'h22;
        it.sel = 1'b1;
        it.data = 32'h22;
        sb_q.push_back(it);
        for (int i = 0; i < 5; i++) begin
            out1_ready = ~out1_ready;
            #1;
            check("bp_in_ready",   {63'd0, in_ready},   64'd0);
            check("bp_out0_valid", {63'd0, out0_valid}, 64'd1);
            check("bp_out0_data",  {32'd0, out0_data},  64'h11);
            step(1);
        end
        out1_ready = 1'b0;
        out0_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        step(1);
        in_valid = 1'b0;
        check("bp_next_out1_valid", {63'd0, out1_valid}, 64'd1);
        check("bp_next_out1_data",  {32'd0, out1_data},  64'h22);
        check("bp_next_out0_valid", {63'd0, out0_valid}, 64'd0);
        out1_ready = 1'b1;
        step(2);

        // Streaming: words 1..8 alternate between ports at one word per cycle.
        t0 = cyc;
        p0 = n_pop;
        for (int w = 1; w <= 8; w++) send(w[0] ? 1'b0 : 1'b1, DW'(w));
        check("stream_accept_cycles", 64'(cyc - t0), 64'd8);
        step(1);
        check("stream_pops", 64'(n_pop - p0), 64'd8);

        // Simultaneous push and pop with no bubble.
        out0_ready = 1'b0;
        send(1'b0, 32'hA);
        out0_ready = 1'b1;
        t0 = cyc;
        send(1'b1, 32'hB);
        check("swap_no_bubble", 64'(cyc - t0), 64'd1);
        check("swap_out1_valid", {63'd0, out1_valid}, 64'd1);
        check("swap_out1_data",  {32'd0, out1_data},  64'hB);
        check("swap_out0_valid", {63'd0, out0_valid}, 64'd0);
        step(2);

        // Asynchronous reset while a word is held.
        out0_ready = 1'b0;
        send(1'b0, 32'h55);
        check("pre_rst_full", {63'd0, out0_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_out0_valid", {63'd0, out0_valid}, 64'd0);
        check("mid_rst_out1_valid", {63'd0, out1_valid}, 64'd0);
        check("mid_rst_in_ready",   {63'd0, in_ready},   64'd1);
        check("mid_rst_data",       {32'd0, out0_data},  64'd0);
        check("mid_rst_cnt0",       {60'd0, cnt0},       64'd0);
        check("mid_rst_cnt1",       {60'd0, cnt1},       64'd0);
        out0_ready = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);

        // Counters: 17 pops to port 0 and 3 to port 1 from a clean reset.
        for (int k = 0; k < 17; k++) send(1'b0, DW'(32'h100 + k));
        for (int k = 0; k < 3; k++)  send(1'b1, DW'(32'h200 + k));
        step(3);
`ifdef DEMUX2_CNT_EN
        check("cnt0_wrap", {60'd0, cnt0}, 64'(17 % 16));
        check("cnt1",      {60'd0, cnt1}, 64'd3);
`else
        check("cnt0_off",  {60'd0, cnt0}, 64'd0);
        check("cnt1_off",  {60'd0, cnt1}, 64'd0);
`endif

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
